// File: rtl/spi_cmd_ram_pkg.sv
// Shared types for the SPI command RAM: command opcodes, TX state encoding,
// and modular address helpers.
package spi_cmd_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_HOLD = 1'b1
  } tx_state_e;

  function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned depth);
    return idx % depth;
  endfunction

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned depth);
    return (idx + 1) % depth;
  endfunction

endpackage

// File: rtl/spi_cmd_ram_mem.sv
// Word storage for spi_cmd_ram: one synchronous write port, one combinational
// read port, no reset so contents survive a reset of the control logic.
module spi_cmd_ram_mem #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read lets a word written on one edge be read on the next.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/spi_cmd_ram.sv
// Command-driven RAM: address/data opcodes arrive on din, read data leaves on a
// valid/ready port. Define SPI_CMD_RAM_AUTO_INC_EN for post-access address increment.
module spi_cmd_ram
  import spi_cmd_ram_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  input  logic              tx_ready,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              err
);

  if (DATA_W < ADDR_W) begin : g_bad_data_w
    $error("spi_cmd_ram: DATA_W must be >= ADDR_W");
  end
  if (longint'(MEM_DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $error("spi_cmd_ram: MEM_DEPTH must be <= 2**ADDR_W");
  end

  // TX handshake: dout is valid while tx_valid=1 and is consumed on any edge
  // where tx_valid=1 and tx_ready=1; dout never changes while tx_valid=1 and
  // tx_ready=0.
  tx_state_e         tx_state_q, tx_state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              err_q, err_d;

  cmd_e              cmd;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] addr_in;
  logic              rd_cmd;
  logic              load;
  logic              drop;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign cmd     = cmd_e'(din[DATA_W+1:DATA_W]);
  assign payload = din[DATA_W-1:0];
  assign addr_in = ADDR_W'(wrap_idx(32'(payload[ADDR_W-1:0]), MEM_DEPTH));
  assign rd_cmd  = rx_valid && (cmd == CMD_RD_DATA);

  spi_cmd_ram_mem #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr_q),
    .wdata (payload),
    .raddr (rd_addr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    err_d      = err_q;
    tx_state_d = tx_state_q;
    mem_we     = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;

    if (rx_valid) begin
      unique case (cmd)
        CMD_WR_ADDR: wr_addr_d = addr_in;
        CMD_WR_DATA: begin
          mem_we = 1'b1;
`ifdef SPI_CMD_RAM_AUTO_INC_EN
          wr_addr_d = ADDR_W'(next_idx(32'(wr_addr_q), MEM_DEPTH));
`endif
        end
        CMD_RD_ADDR: rd_addr_d = addr_in;
        CMD_RD_DATA: ;
      endcase
    end

    unique case (tx_state_q)
      TX_IDLE: begin
        if (rd_cmd) begin
          load       = 1'b1;
          tx_state_d = TX_HOLD;
        end
      end
      TX_HOLD: begin
        if (tx_ready) begin
          if (rd_cmd) begin
            load = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else if (rd_cmd) begin
          // Previous word still unclaimed: refuse the read rather than lose it.
          drop = 1'b1;
        end
      end
    endcase

    if (load) begin
      dout_d = mem_rdata;
`ifdef SPI_CMD_RAM_AUTO_INC_EN
      rd_addr_d = ADDR_W'(next_idx(32'(rd_addr_q), MEM_DEPTH));
`endif
    end

    // A drop in the same cycle as a clear wins so no drop goes unreported.
    err_d = (err_q && !err_clr) || drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      err_q      <= err_d;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = (tx_state_q == TX_HOLD);
  assign err      = err_q;

endmodule

// File: tb/tb_spi_cmd_ram.sv
// Self-checking bench for spi_cmd_ram: directed scenarios plus randomized
// command streams checked against a behavioural model of the command set.
module tb_spi_cmd_ram;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [9:0]  din;
  logic        tx_ready;
  logic        err_clr;
  logic [7:0]  dout;
  logic        tx_valid;
  logic        err;

  logic        rx_valid16;
  logic [17:0] din16;
  logic        tx_ready16;
  logic        err_clr16;
  logic [15:0] dout16;
  logic        tx_valid16;
  logic        err16;

  int n_vec;
  int n_err;

  // Reference model state
  logic [7:0]  m_mem [DEPTH];
  int unsigned m_wr;
  int unsigned m_rd;
  logic        m_valid;
  logic        m_err;
  logic [7:0]  m_dout;

  spi_cmd_ram u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .din      (din),
    .tx_ready (tx_ready),
    .err_clr  (err_clr),
    .dout     (dout),
    .tx_valid (tx_valid),
    .err      (err)
  );

  spi_cmd_ram #(
    .ADDR_W    (4),
    .DATA_W    (16),
    .MEM_DEPTH (16)
  ) u_dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid16),
    .din      (din16),
    .tx_ready (tx_ready16),
    .err_clr  (err_clr16),
    .dout     (dout16),
    .tx_valid (tx_valid16),
    .err      (err16)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Behavioural model: one call per rising edge with that cycle's inputs
  function automatic void model_clock(input logic v, input logic [1:0] op,
                                      input logic [7:0] pl, input logic rdy,
                                      input logic clr);
    logic is_rd;
    logic dropped;
    is_rd   = v && (op == 2'b11);
    dropped = is_rd && m_valid && !rdy;
    m_err   = (m_err && !clr) || dropped;
    if (v) begin
      case (op)
        2'b00: m_wr = pl % DEPTH;
        2'b01: begin
          m_mem[m_wr] = pl;
`ifdef SPI_CMD_RAM_AUTO_INC_EN
          m_wr = (m_wr + 1) % DEPTH;
`endif
        end
        2'b10: m_rd = pl % DEPTH;
        default: begin
          if (!dropped) begin
            m_dout = m_mem[m_rd];
`ifdef SPI_CMD_RAM_AUTO_INC_EN
            m_rd = (m_rd + 1) % DEPTH;
`endif
          end
        end
      endcase
    end
    if (is_rd && !dropped) m_valid = 1'b1;
    else if (m_valid && rdy) m_valid = 1'b0;
  endfunction

  function automatic void model_reset();
    m_wr    = 0;
    m_rd    = 0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_dout  = 8'h00;
  endfunction

  // Driver tasks
  task automatic step(input logic v, input logic [1:0] op, input logic [7:0] pl,
                      input logic rdy, input logic clr);
    rx_valid = v;
    din      = {op, pl};
    tx_ready = rdy;
    err_clr  = clr;
    @(posedge clk);
    model_clock(v, op, pl, rdy, clr);
    #1;
  endtask

  task automatic step16(input logic v, input logic [1:0] op, input logic [15:0] pl,
                        input logic rdy);
    rx_valid16 = v;
    din16      = {op, pl};
    tx_ready16 = rdy;
    err_clr16  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    step(1'b0, 2'b00, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rx_valid = 1'b0; din = '0; tx_ready = 1'b0; err_clr = 1'b0;
    rx_valid16 = 1'b0; din16 = '0; tx_ready16 = 1'b0; err_clr16 = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h expected 00", dout); end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err); end
    n_vec++; if ({dout16, tx_valid16, err16} !== 18'h0) begin n_err++; $display("FAIL reset_dut16: got %h expected 0", {dout16, tx_valid16, err16}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic init_mem();
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b1, 2'b00, 8'(a), 1'b1, 1'b0);
      step(1'b1, 2'b01, 8'($urandom_range(255)), 1'b1, 1'b0);
    end
  endtask

  task automatic test_basic();
    flush();
    step(1'b1, 2'b00, 8'h10, 1'b1, 1'b0);
    step(1'b1, 2'b01, 8'h5A, 1'b1, 1'b0);
    step(1'b1, 2'b10, 8'h10, 1'b1, 1'b0);
    step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
    n_vec++; if (tx_valid !== 1'b1 || dout !== 8'h5A) begin n_err++; $display("FAIL basic_read: got valid=%b dout=%h expected valid=1 dout=5a", tx_valid, dout); end
    step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL basic_one_cycle: got valid=%b expected 0", tx_valid); end
  endtask

  task automatic test_drop();
    logic [7:0] exp_second;
`ifdef SPI_CMD_RAM_AUTO_INC_EN
    exp_second = 8'h44;
`else
    exp_second = 8'h33;
`endif
    flush();
    step(1'b1, 2'b00, 8'h20, 1'b0, 1'b0);
    step(1'b1, 2'b01, 8'h33, 1'b0, 1'b0);
    step(1'b1, 2'b00, 8'h21, 1'b0, 1'b0);
    step(1'b1, 2'b01, 8'h44, 1'b0, 1'b0);
    step(1'b1, 2'b10, 8'h20, 1'b0, 1'b0);
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
    n_vec++; if (tx_valid !== 1'b1 || dout !== 8'h33) begin n_err++; $display("FAIL drop_first: got valid=%b dout=%h expected valid=1 dout=33", tx_valid, dout); end
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL drop_err: got %b expected 1", err); end
    n_vec++; if (tx_valid !== 1'b1 || dout !== 8'h33) begin n_err++; $display("FAIL drop_hold: got valid=%b dout=%h expected valid=1 dout=33", tx_valid, dout); end
    step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    n_vec++; if (tx_valid !== 1'b0 || err !== 1'b1) begin n_err++; $display("FAIL drop_accept: got valid=%b err=%b expected valid=0 err=1", tx_valid, err); end
    step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
    n_vec++; if (dout !== exp_second) begin n_err++; $display("FAIL drop_rd_addr_kept: got %h expected %h", dout, exp_second); end
    step(1'b0, 2'b00, 8'h00, 1'b1, 1'b1);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clr: got %b expected 0", err); end
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b1);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL clr_with_drop: got %b expected 1", err); end
    step(1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL clr_after_drop: got %b expected 0", err); end
  endtask

  task automatic test_back_to_back();
    flush();
    step(1'b1, 2'b00, 8'h30, 1'b1, 1'b0);
    step(1'b1, 2'b01, 8'h77, 1'b1, 1'b0);
    step(1'b1, 2'b00, 8'h31, 1'b1, 1'b0);
    step(1'b1, 2'b01, 8'h88, 1'b1, 1'b0);
    step(1'b1, 2'b10, 8'h30, 1'b0, 1'b0);
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
    n_vec++; if (tx_valid !== 1'b1 || dout !== 8'h77) begin n_err++; $display("FAIL b2b_first: got valid=%b dout=%h expected valid=1 dout=77", tx_valid, dout); end
    step(1'b1, 2'b10, 8'h31, 1'b0, 1'b0);
    n_vec++; if (tx_valid !== 1'b1 || dout !== 8'h77) begin n_err++; $display("FAIL b2b_stable: got valid=%b dout=%h expected valid=1 dout=77", tx_valid, dout); end
    step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
    n_vec++; if (tx_valid !== 1'b1 || dout !== 8'h88) begin n_err++; $display("FAIL b2b_second: got valid=%b dout=%h expected valid=1 dout=88", tx_valid, dout); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL b2b_no_err: got %b expected 0", err); end
    step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL b2b_release: got %b expected 0", tx_valid); end
  endtask

  task automatic test_addr_mode();
    flush();
`ifdef SPI_CMD_RAM_AUTO_INC_EN
    step(1'b1, 2'b00, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 2'b01, 8'h11, 1'b1, 1'b0);
    step(1'b1, 2'b01, 8'h22, 1'b1, 1'b0);
    step(1'b1, 2'b10, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
    n_vec++; if (dout !== 8'h11) begin n_err++; $display("FAIL autoinc_ff: got %h expected 11", dout); end
    step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
    n_vec++; if (dout !== 8'h22) begin n_err++; $display("FAIL autoinc_wrap: got %h expected 22", dout); end
`else
    step(1'b1, 2'b00, 8'h40, 1'b1, 1'b0);
    step(1'b1, 2'b01, 8'h11, 1'b1, 1'b0);
    step(1'b1, 2'b01, 8'h22, 1'b1, 1'b0);
    step(1'b1, 2'b10, 8'h40, 1'b1, 1'b0);
    step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
    n_vec++; if (dout !== 8'h22) begin n_err++; $display("FAIL fixed_wr_addr: got %h expected 22", dout); end
    step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
    n_vec++; if (dout !== 8'h22) begin n_err++; $display("FAIL fixed_rd_addr: got %h expected 22", dout); end
`endif
    step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    flush();
    step(1'b1, 2'b00, 8'h03, 1'b0, 1'b0);
    step(1'b1, 2'b01, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 2'b10, 8'h03, 1'b0, 1'b0);
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
    n_vec++; if (tx_valid !== 1'b1 || err !== 1'b1) begin n_err++; $display("FAIL pre_reset: got valid=%b err=%b expected 1 1", tx_valid, err); end
    rx_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_vec++; if ({dout, tx_valid, err} !== 10'h0) begin n_err++; $display("FAIL mid_reset_outputs: got %h expected 0", {dout, tx_valid, err}); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL no_represent: got %b expected 0", tx_valid); end
    step(1'b1, 2'b10, 8'h03, 1'b1, 1'b0);
    step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
    n_vec++; if (tx_valid !== 1'b1 || dout !== 8'hA5) begin n_err++; $display("FAIL mem_kept: got valid=%b dout=%h expected valid=1 dout=a5", tx_valid, dout); end
    step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_param16();
    step16(1'b1, 2'b00, 16'h0013, 1'b1);
    step16(1'b1, 2'b01, 16'hBEEF, 1'b1);
    step16(1'b1, 2'b00, 16'h0005, 1'b1);
    step16(1'b1, 2'b01, 16'h1234, 1'b1);
    step16(1'b1, 2'b10, 16'h0003, 1'b1);
    step16(1'b1, 2'b11, 16'h0000, 1'b1);
    n_vec++; if (tx_valid16 !== 1'b1 || dout16 !== 16'hBEEF) begin n_err++; $display("FAIL p16_wrap_write: got valid=%b dout=%h expected valid=1 dout=beef", tx_valid16, dout16); end
    step16(1'b1, 2'b10, 16'h0015, 1'b1);
    step16(1'b1, 2'b11, 16'h0000, 1'b1);
    n_vec++; if (tx_valid16 !== 1'b1 || dout16 !== 16'h1234) begin n_err++; $display("FAIL p16_wrap_read: got valid=%b dout=%h expected valid=1 dout=1234", tx_valid16, dout16); end
    step16(1'b0, 2'b00, 16'h0000, 1'b1);
    n_vec++; if (tx_valid16 !== 1'b0 || err16 !== 1'b0) begin n_err++; $display("FAIL p16_idle: got valid=%b err=%b expected 0 0", tx_valid16, err16); end
  endtask

  task automatic test_random();
    logic       v;
    logic [1:0] op;
    logic [7:0] pl;
    logic       rdy;
    logic       clr;
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(3) != 0);
      op  = 2'($urandom_range(3));
      pl  = 8'($urandom_range(255));
      rdy = 1'($urandom_range(1));
      clr = ($urandom_range(7) == 0);
      step(v, op, pl, rdy, clr);
      n_vec++; if (tx_valid !== m_valid) begin n_err++; $display("FAIL rand_tx_valid[%0d]: got %b expected %b", i, tx_valid, m_valid); end
      n_vec++; if (err !== m_err) begin n_err++; $display("FAIL rand_err[%0d]: got %b expected %b", i, err, m_err); end
      n_vec++; if (dout !== m_dout) begin n_err++; $display("FAIL rand_dout[%0d]: got %h expected %h", i, dout, m_dout); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    init_mem();
    test_basic();
    test_drop();
    test_back_to_back();
    test_addr_mode();
    test_reset_mid();
    test_param16();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ram.md
SPI_CMD_RAM -- requirements
Module: spi_cmd_ram

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 8, meaning address width in bits.
REQ-002 The block SHALL take parameter DATA_W, default 8, meaning data width; elaboration fails if DATA_W < ADDR_W.
REQ-003 The block SHALL take parameter MEM_DEPTH, default 256, meaning word count; elaboration fails if MEM_DEPTH > 2**ADDR_W.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port rx_valid, input, 1 bit: din carries a command this cycle.
REQ-007 The block SHALL have port din, input, DATA_W+2 bits: [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload.
REQ-008 The block SHALL have port tx_ready, input, 1 bit: consumer accepts dout this cycle.
REQ-009 The block SHALL have port err_clr, input, 1 bit: clears err.
REQ-010 The block SHALL have port dout, output, DATA_W bits: read data.
REQ-011 The block SHALL have port tx_valid, output, 1 bit: dout valid, held until accepted.
REQ-012 The block SHALL have port err, output, 1 bit: sticky flag, a read-data command was dropped.

Function
REQ-013 Opcode 00 SHALL load wr_addr from payload[ADDR_W-1:0].
REQ-014 Opcode 01 SHALL write payload to mem[wr_addr] at the accepting edge.
REQ-015 Opcode 10 SHALL load rd_addr from payload[ADDR_W-1:0].
REQ-016 Opcode 11 SHALL register mem[rd_addr] into dout and assert tx_valid one cycle after the rx_valid cycle.
REQ-017 Commands SHALL be acted on only when rx_valid=1; rx_valid=0 cycles SHALL change no state except the TX handshake.
REQ-018 An address payload >= MEM_DEPTH SHALL wrap modulo MEM_DEPTH.
REQ-019 The TX FSM SHALL have states TX_IDLE (tx_valid=0) and TX_HOLD (tx_valid=1).
REQ-020 TX_IDLE SHALL go to TX_HOLD on an accepted opcode 11.
REQ-021 TX_HOLD SHALL go to TX_IDLE on tx_ready=1 with no opcode 11 that cycle.
REQ-022 TX_HOLD with tx_ready=1 and an opcode 11 the same cycle SHALL stay in TX_HOLD and load new dout, giving back-to-back data.
REQ-023 TX_HOLD with tx_ready=0 and an opcode 11 SHALL drop the command, hold dout and rd_addr, and set err.
REQ-024 dout SHALL remain stable while tx_valid=1 and tx_ready=0.
REQ-025 Opcode 01 to address A followed next cycle by opcode 11 with rd_addr=A SHALL return the new data.
REQ-026 err_clr=1 SHALL clear err; a drop in the same cycle SHALL leave err set.

Reset
REQ-027 rst_n=0 SHALL immediately force dout=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0, and FSM to TX_IDLE.
REQ-028 Memory contents SHALL NOT be reset; reset mid-operation SHALL preserve every written word.
REQ-029 A read pending in TX_HOLD at reset SHALL be discarded and not re-presented after reset.

Configuration
REQ-030 With macro SPI_CMD_RAM_AUTO_INC_EN defined, each executed opcode 01 SHALL increment wr_addr and each executed opcode 11 SHALL increment rd_addr, both modulo MEM_DEPTH.
REQ-031 A dropped opcode 11 SHALL NOT increment rd_addr.
REQ-032 With SPI_CMD_RAM_AUTO_INC_EN undefined, addresses SHALL change only on opcodes 00 and 10.

Structure
REQ-033 Package spi_cmd_ram_pkg SHALL hold the opcode enum (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA) and the TX state enum.
REQ-034 Storage SHALL be a sub-module spi_cmd_ram_mem: one synchronous write port and one read port, parametrised by DATA_W, ADDR_W, and MEM_DEPTH, with no reset.

Verification
REQ-035 Scenario: write 0x5A to address 0x10, set rd_addr to 0x10, issue opcode 11 with tx_ready=1 -> dout=0x5A and tx_valid high for exactly 1 cycle, one cycle after the command.
REQ-036 Scenario: tx_ready=0, issue opcode 11 twice -> first data is held, second command is dropped, err=1, and rd_addr is unchanged; err_clr -> err=0.
REQ-037 Scenario: TX_HOLD with tx_ready=1 and opcode 11 the same cycle -> tx_valid stays 1 and dout updates to the next word.
REQ-038 Scenario (AUTO_INC_EN): wr_addr=0xFF, write 0x11 then 0x22 -> mem[0xFF]=0x11 and mem[0x00]=0x22; reads wrap identically.
REQ-039 Scenario: write 0xA5 to address 0x03, pulse rst_n, then read address 0x03 -> dout=0xA5; all outputs are 0 during reset.
REQ-040 Scenario: DATA_W=16, ADDR_W=4, MEM_DEPTH=16, address payload 0x13 -> accesses address 0x3; 16-bit data round-trips intact.
